// File: rtl/psram_rd_capture_pkg.sv
// Shared definitions for the PSRAM read-capture sequencer: FSM states,
// the IDDR pipeline depth and default geometry.
package psram_rd_capture_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LAT = 2'd1,
        CAPTURE  = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int IDDR_PIPE         = 2;
    localparam int DEFAULT_DQ_W      = 8;
    localparam int DEFAULT_BURST_LEN = 4;
    localparam int DEFAULT_TIMEOUT   = 63;

endpackage

// File: rtl/psram_rd_capture.sv
// Read-data capture sequencer: waits the read latency, qualifies IDDR output
// pairs with the captured RWDS strobe, assembles words and counts the burst.
module psram_rd_capture
    import psram_rd_capture_pkg::*;
#(
    parameter int DQ_W      = DEFAULT_DQ_W,
    parameter int BURST_LEN = DEFAULT_BURST_LEN,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [3:0]        latency,
    input  logic [DQ_W-1:0]   iddr_q0,
    input  logic [DQ_W-1:0]   iddr_q1,
    input  logic              rwds_q0,
    input  logic              rwds_q1,
    output logic              busy,
    output logic [2*DQ_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              rdata_last,
    output logic              done,
    output logic              timeout_err
);

    localparam int LAT_W  = 5;
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    state_t              state, state_next;
    logic [LAT_W-1:0]    lat_cnt, lat_cnt_next;
    logic [BEAT_W-1:0]   beat_cnt, beat_cnt_next;
    logic [TO_W-1:0]     to_cnt, to_cnt_next;
    logic [2*DQ_W-1:0]   rdata_next;
    logic                busy_next, valid_next, last_next, done_next, err_next;
    logic                beat_qual;

    // A beat is a rising-edge-high / falling-edge-low RWDS pair from the IDDR.
    assign beat_qual = rwds_q0 & ~rwds_q1;

    always_comb begin
        state_next    = state;
        lat_cnt_next  = lat_cnt;
        beat_cnt_next = beat_cnt;
        to_cnt_next   = to_cnt;
        rdata_next    = rdata;
        busy_next     = busy;
        valid_next    = 1'b0;
        last_next     = 1'b0;
        done_next     = 1'b0;
        err_next      = 1'b0;
        case (state)
            IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    lat_cnt_next  = {1'b0, latency} + LAT_W'(IDDR_PIPE - 1);
                    beat_cnt_next = '0;
                    to_cnt_next   = '0;
                    busy_next     = 1'b1;
                    state_next    = WAIT_LAT;
                end
            end
            WAIT_LAT: begin
                if (lat_cnt == '0) state_next   = CAPTURE;
                else               lat_cnt_next = lat_cnt - LAT_W'(1);
            end
            CAPTURE: begin
                if (beat_qual) begin
                    rdata_next    = {iddr_q0, iddr_q1};
                    valid_next    = 1'b1;
                    beat_cnt_next = beat_cnt + BEAT_W'(1);
                    to_cnt_next   = '0;
                    if (beat_cnt == BEAT_W'(BURST_LEN - 1)) begin
                        last_next  = 1'b1;
                        state_next = DONE;
                    end
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end else begin
                    to_cnt_next = to_cnt + TO_W'(1);
                end
            end
            DONE: begin
                done_next  = 1'b1;
                busy_next  = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            beat_cnt    <= '0;
            to_cnt      <= '0;
            rdata       <= '0;
            busy        <= 1'b0;
            rdata_valid <= 1'b0;
            rdata_last  <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            lat_cnt     <= lat_cnt_next;
            beat_cnt    <= beat_cnt_next;
            to_cnt      <= to_cnt_next;
            rdata       <= rdata_next;
            busy        <= busy_next;
            rdata_valid <= valid_next;
            rdata_last  <= last_next;
            done        <= done_next;
            timeout_err <= err_next;
        end
    end

endmodule

// File: tb/tb_psram_rd_capture.sv
// Bench for psram_rd_capture: per-cycle schedules of start/RWDS/DQ are driven
// into the DUT and its outputs compared against a burst-level trace model.
module tb_psram_rd_capture;

    localparam int NCYC    = 120;
    localparam int BL      = 4;
    localparam int TMO     = 63;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  latency;
    logic [7:0]  iddr_q0, iddr_q1;
    logic        rwds_q0, rwds_q1;
    logic        busy;
    logic [15:0] rdata;
    logic        rdata_valid, rdata_last, done, timeout_err;

    int tests = 0;
    int failed = 0;

    // per-cycle schedule: index k = inputs sampled at the k-th edge after start
    logic        st  [NCYC];
    logic [1:0]  rw  [NCYC];
    logic [15:0] dw  [NCYC];
    logic [3:0]  lat_v;
    // control packing: {busy, valid, last, done, timeout_err}
    logic [4:0]  obs_ctl [NCYC];
    logic [15:0] obs_data[NCYC];
    logic [4:0]  exp_ctl [NCYC];
    logic [15:0] exp_data[NCYC];

    psram_rd_capture #(.DQ_W(8), .BURST_LEN(BL), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .latency(latency),
        .iddr_q0(iddr_q0), .iddr_q1(iddr_q1), .rwds_q0(rwds_q0), .rwds_q1(rwds_q1),
        .busy(busy), .rdata(rdata), .rdata_valid(rdata_valid), .rdata_last(rdata_last),
        .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] nonqual();
        case ($urandom_range(0, 2))
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    // Fresh schedule: single start at k=0, random data, random strobe noise
    // (including qualified pairs) before capture opens, no beats afterwards.
    task automatic init_sched(input logic [3:0] lat);
        lat_v = lat;
        for (int k = 0; k < NCYC; k++) begin
            st[k] = (k == 0);
            dw[k] = 16'($urandom);
            if (k < int'(lat) + 3 && $urandom_range(0, 1) == 1) rw[k] = 2'b10;
            else                                                 rw[k] = nonqual();
        end
    endtask

    // Burst-level reference: capture opens latency+IDDR_PIPE+1 edges after
    // start; each qualified pair is a word; BL words then done one edge later;
    // TMO consecutive unqualified pairs abort. busy covers start..end.
    function automatic void model();
        int kcap, n, gap, kend;
        kcap = int'(lat_v) + 3;
        n = 0; gap = 0; kend = NCYC;
        for (int k = 0; k < NCYC; k++) begin
            exp_ctl[k]  = 5'b0;
            exp_data[k] = 16'h0;
        end
        for (int k = kcap; k < NCYC; k++) begin
            if (rw[k] == 2'b10) begin
                exp_ctl[k][3] = 1'b1;
                exp_data[k]   = dw[k];
                n++; gap = 0;
                if (n == BL) begin
                    exp_ctl[k][2] = 1'b1;
                    if (k + 1 < NCYC) exp_ctl[k+1][1] = 1'b1;
                    kend = k + 1;
                    break;
                end
            end else begin
                gap++;
                if (gap == TMO) begin
                    exp_ctl[k][0] = 1'b1;
                    kend = k;
                    break;
                end
            end
        end
        for (int k = 0; k < NCYC; k++)
            if (k < kend) exp_ctl[k][4] = 1'b1;
    endfunction

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            start   = st[k];
            latency = lat_v;
            iddr_q0 = dw[k][15:8];
            iddr_q1 = dw[k][7:0];
            {rwds_q0, rwds_q1} = rw[k];
            @(posedge clk);
            #1;
            obs_ctl[k]  = {busy, rdata_valid, rdata_last, done, timeout_err};
            obs_data[k] = rdata;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; start = 1'b0; latency = 4'd0;
        iddr_q0 = 8'h0; iddr_q1 = 8'h0; rwds_q0 = 1'b0; rwds_q1 = 1'b0;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy, rdata_valid, rdata_last, done, timeout_err} !== 5'b0) begin
            failed++; $display("FAIL reset_ctl got %b want 00000", {busy, rdata_valid, rdata_last, done, timeout_err});
        end
        tests++;
        if (rdata !== 16'h0) begin
            failed++; $display("FAIL reset_rdata got %h want 0000", rdata);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int nv;
        logic [15:0] words [4];
        words[0] = 16'h1234; words[1] = 16'h5678; words[2] = 16'h9ABC; words[3] = 16'hDEF0;
        init_sched(4'd3);
        for (int i = 0; i < 4; i++) begin rw[6+i] = 2'b10; dw[6+i] = words[i]; end
        model(); run(NCYC);
        for (int k = 0; k < NCYC; k++) begin
            tests++;
            if (obs_ctl[k] !== exp_ctl[k]) begin
                failed++; $display("FAIL b2b_ctl k=%0d got %b want %b", k, obs_ctl[k], exp_ctl[k]);
            end
            if (exp_ctl[k][3]) begin
                tests++;
                if (obs_data[k] !== exp_data[k]) begin
                    failed++; $display("FAIL b2b_data k=%0d got %h want %h", k, obs_data[k], exp_data[k]);
                end
            end
        end
        nv = 0;
        for (int k = 0; k < NCYC; k++) nv += int'(obs_ctl[k][3]);
        tests++;
        if (nv != 4) begin failed++; $display("FAIL b2b_count got %0d want 4", nv); end
        tests++;
        if (obs_ctl[5][3] !== 1'b0 || obs_ctl[6][3] !== 1'b1 || obs_data[6] !== 16'h1234) begin
            failed++; $display("FAIL b2b_first valid5=%b valid6=%b data6=%h want 0 1 1234", obs_ctl[5][3], obs_ctl[6][3], obs_data[6]);
        end
        tests++;
        if (obs_ctl[9][2] !== 1'b1 || obs_data[9] !== 16'hDEF0 || obs_ctl[10][1] !== 1'b1) begin
            failed++; $display("FAIL b2b_last last9=%b data9=%h done10=%b want 1 DEF0 1", obs_ctl[9][2], obs_data[9], obs_ctl[10][1]);
        end
    endtask

    task automatic test_latency_zero();
        init_sched(4'd0);
        for (int i = 0; i < 4; i++) rw[3+i] = 2'b10;
        model(); run(NCYC);
        for (int k = 0; k < NCYC; k++) begin
            tests++;
            if (obs_ctl[k] !== exp_ctl[k]) begin
                failed++; $display("FAIL lat0_ctl k=%0d got %b want %b", k, obs_ctl[k], exp_ctl[k]);
            end
            if (exp_ctl[k][3]) begin
                tests++;
                if (obs_data[k] !== exp_data[k]) begin
                    failed++; $display("FAIL lat0_data k=%0d got %h want %h", k, obs_data[k], exp_data[k]);
                end
            end
        end
        tests++;
        if (obs_ctl[2][3] !== 1'b0 || obs_ctl[3][3] !== 1'b1) begin
            failed++; $display("FAIL lat0_first valid2=%b valid3=%b want 0 1", obs_ctl[2][3], obs_ctl[3][3]);
        end
    endtask

    task automatic test_pause();
        int kc, nv, ne;
        init_sched(4'($urandom_range(0, 15)));
        kc = int'(lat_v) + 3;
        rw[kc] = 2'b10; rw[kc+1] = 2'b10; rw[kc+7] = 2'b10; rw[kc+8] = 2'b10;
        model(); run(NCYC);
        nv = 0; ne = 0;
        for (int k = 0; k < NCYC; k++) begin
            nv += int'(obs_ctl[k][3]);
            ne += int'(obs_ctl[k][0]);
            tests++;
            if (obs_ctl[k] !== exp_ctl[k]) begin
                failed++; $display("FAIL pause_ctl k=%0d got %b want %b", k, obs_ctl[k], exp_ctl[k]);
            end
            if (exp_ctl[k][3]) begin
                tests++;
                if (obs_data[k] !== exp_data[k]) begin
                    failed++; $display("FAIL pause_data k=%0d got %h want %h", k, obs_data[k], exp_data[k]);
                end
            end
        end
        tests++;
        if (nv != 4 || ne != 0) begin
            failed++; $display("FAIL pause_count valids=%0d errs=%0d want 4 0", nv, ne);
        end
    endtask

    task automatic test_timeout();
        int kc, nv, nd;
        init_sched(4'($urandom_range(0, 15)));
        kc = int'(lat_v) + 3;
        model(); run(NCYC);
        nv = 0; nd = 0;
        for (int k = 0; k < NCYC; k++) begin
            nv += int'(obs_ctl[k][3]);
            nd += int'(obs_ctl[k][1]);
            tests++;
            if (obs_ctl[k] !== exp_ctl[k]) begin
                failed++; $display("FAIL tmo_ctl k=%0d got %b want %b", k, obs_ctl[k], exp_ctl[k]);
            end
        end
        tests++;
        if (obs_ctl[kc+62] !== 5'b00001 || obs_ctl[kc+61] !== 5'b10000) begin
            failed++; $display("FAIL tmo_edge at=%b before=%b want 00001 10000", obs_ctl[kc+62], obs_ctl[kc+61]);
        end
        tests++;
        if (nv != 0 || nd != 0) begin
            failed++; $display("FAIL tmo_count valids=%0d dones=%0d want 0 0", nv, nd);
        end
    endtask

    task automatic test_start_ignored();
        int kc, nd;
        init_sched(4'($urandom_range(0, 15)));
        kc = int'(lat_v) + 3;
        for (int i = 0; i < 4; i++) rw[kc+i] = 2'b10;
        st[2] = 1'b1; st[kc+1] = 1'b1; st[kc+4] = 1'b1;
        model(); run(NCYC);
        nd = 0;
        for (int k = 0; k < NCYC; k++) begin
            nd += int'(obs_ctl[k][1]);
            tests++;
            if (obs_ctl[k] !== exp_ctl[k]) begin
                failed++; $display("FAIL ign_ctl k=%0d got %b want %b", k, obs_ctl[k], exp_ctl[k]);
            end
            if (exp_ctl[k][3]) begin
                tests++;
                if (obs_data[k] !== exp_data[k]) begin
                    failed++; $display("FAIL ign_data k=%0d got %h want %h", k, obs_data[k], exp_data[k]);
                end
            end
        end
        tests++;
        if (nd != 1) begin failed++; $display("FAIL ign_dones got %0d want 1", nd); end
    endtask

    task automatic test_reset_mid_burst();
        init_sched(4'd2);
        for (int i = 0; i < 4; i++) rw[5+i] = 2'b10;
        run(7);
        #3 reset_n = 1'b0;
        #1;
        tests++;
        if ({busy, rdata_valid, rdata_last, done, timeout_err} !== 5'b0 || rdata !== 16'h0) begin
            failed++; $display("FAIL midrst_out ctl=%b rdata=%h want 00000 0000", {busy, rdata_valid, rdata_last, done, timeout_err}, rdata);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        init_sched(4'($urandom_range(0, 15)));
        for (int i = 0; i < 4; i++) rw[int'(lat_v)+3+i] = 2'b10;
        model(); run(NCYC);
        for (int k = 0; k < NCYC; k++) begin
            tests++;
            if (obs_ctl[k] !== exp_ctl[k]) begin
                failed++; $display("FAIL midrst_ctl k=%0d got %b want %b", k, obs_ctl[k], exp_ctl[k]);
            end
            if (exp_ctl[k][3]) begin
                tests++;
                if (obs_data[k] !== exp_data[k]) begin
                    failed++; $display("FAIL midrst_data k=%0d got %h want %h", k, obs_data[k], exp_data[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            init_sched(4'($urandom_range(0, 15)));
            for (int k = int'(lat_v) + 3; k < NCYC; k++)
                if ($urandom_range(0, 9) < 6) rw[k] = 2'b10;
            model(); run(NCYC);
            for (int k = 0; k < NCYC; k++) begin
                tests++;
                if (obs_ctl[k] !== exp_ctl[k]) begin
                    failed++; $display("FAIL rand%0d_ctl k=%0d got %b want %b", it, k, obs_ctl[k], exp_ctl[k]);
                end
                if (exp_ctl[k][3]) begin
                    tests++;
                    if (obs_data[k] !== exp_data[k]) begin
                        failed++; $display("FAIL rand%0d_data k=%0d got %h want %h", it, k, obs_data[k], exp_data[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_latency_zero();
        test_pause();
        test_timeout();
        test_start_ignored();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
